// File: rtl/updown_pkg.sv
// rtl/updown_pkg.sv - shared types, default widths and config check for the bounce controller
package updown_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_BW    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEEK,
        ST_UP,
        ST_DOWN,
        ST_DONE
    } state_t;

    // Widened to 32 bits so hi >= lo + 2 never wraps at the top of the count range.
    function automatic logic cfg_ok(input int unsigned lo, input int unsigned hi,
                                    input int unsigned turns);
        return (hi >= lo + 32'd2) && (turns != 32'd0);
    endfunction

endpackage

// File: rtl/Up_Down_Counter.sv
// rtl/Up_Down_Counter.sv - free-running up/down counter steered by the bounce controller
module Up_Down_Counter #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_m,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_m) begin
            r_count <= r_count + WIDTH'(1);
        end else begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/updown_bounce_ctrl.sv
// rtl/updown_bounce_ctrl.sv - drives counter mode so count bounces between lo and hi for N turns
module updown_bounce_ctrl
    import updown_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BW    = DEF_BW
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [BW-1:0]    i_turns,
    input  logic [WIDTH-1:0] i_count,
    output logic             o_m,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_cfg_err,
    output logic [BW-1:0]    o_turn_cnt
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_lo_q;
    logic [WIDTH-1:0] r_hi_q;
    logic [BW-1:0]    r_tgt_q;
    logic [BW-1:0]    r_turn_cnt;
    logic             r_cfg_err;

    logic             w_cap;
    logic             w_turn;
    logic             w_cfg_err_nxt;
    logic             w_cfg_ok;
    logic [BW-1:0]    w_turn_inc;
    logic [WIDTH-1:0] w_hi_m1;
    logic [WIDTH-1:0] w_lo_p1;

    assign w_cfg_ok   = cfg_ok(32'(i_lo), 32'(i_hi), 32'(i_turns));
    assign w_turn_inc = r_turn_cnt + BW'(1);
    // Turn one count early: m is registered, so the counter lands on the limit with the flip.
    assign w_hi_m1    = r_hi_q - WIDTH'(1);
    assign w_lo_p1    = r_lo_q + WIDTH'(1);

    always_comb begin
        w_state_nxt   = r_state;
        w_cap         = 1'b0;
        w_turn        = 1'b0;
        w_cfg_err_nxt = 1'b0;
        if (i_abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (w_cfg_ok) begin
                            w_cap       = 1'b1;
                            w_state_nxt = ST_SEEK;
                        end else begin
                            w_cfg_err_nxt = 1'b1;
                        end
                    end
                end
                ST_SEEK: begin
                    if (i_count == r_lo_q) w_state_nxt = ST_UP;
                end
                ST_UP: begin
                    if (i_count == w_hi_m1) begin
                        w_turn      = 1'b1;
                        w_state_nxt = (w_turn_inc == r_tgt_q) ? ST_DONE : ST_DOWN;
                    end
                end
                ST_DOWN: begin
                    if (i_count == w_lo_p1) begin
                        w_turn      = 1'b1;
                        w_state_nxt = (w_turn_inc == r_tgt_q) ? ST_DONE : ST_UP;
                    end
                end
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_lo_q     <= '0;
            r_hi_q     <= '0;
            r_tgt_q    <= '0;
            r_turn_cnt <= '0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cfg_err <= w_cfg_err_nxt;
            if (w_cap) begin
                r_lo_q     <= i_lo;
                r_hi_q     <= i_hi;
                r_tgt_q    <= i_turns;
                r_turn_cnt <= '0;
            end else if (w_turn) begin
                r_turn_cnt <= w_turn_inc;
            end
        end
    end

    assign o_m        = (r_state != ST_DOWN);
    assign o_busy     = (r_state == ST_SEEK) || (r_state == ST_UP) || (r_state == ST_DOWN);
    assign o_done     = (r_state == ST_DONE);
    assign o_cfg_err  = r_cfg_err;
    assign o_turn_cnt = r_turn_cnt;

endmodule

// File: tb/tb_updown_bounce_ctrl.sv
// tb/tb_updown_bounce_ctrl.sv - closed-loop bench for updown_bounce_ctrl with Up_Down_Counter
module tb_updown_bounce_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [7:0] turns;
    logic [3:0] count;
    logic       m;
    logic       busy;
    logic       done;
    logic       cfg_err;
    logic [7:0] turn_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    int exp_cnt[$];
    int exp_tc[$];

    typedef struct {
        int l;
        int h;
        int t;
        int valid;
    } vec_t;

    always #5 clk = ~clk;

    updown_bounce_ctrl #(.WIDTH(4), .BW(8)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_start    (start),
        .i_abort    (abort),
        .i_lo       (lo),
        .i_hi       (hi),
        .i_turns    (turns),
        .i_count    (count),
        .o_m        (m),
        .o_busy     (busy),
        .o_done     (done),
        .o_cfg_err  (cfg_err),
        .o_turn_cnt (turn_cnt)
    );

    Up_Down_Counter #(.WIDTH(4)) cnt (
        .i_clk   (clk),
        .i_reset (reset),
        .i_m     (m),
        .o_count (count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_count(input int v, input string nm);
        int k = 0;
        while (count !== 4'(v) && k < 40) begin
            tick;
            k++;
        end
        chk(nm, count, v);
    endtask

    // Expected counter trajectory after an accepted start: seek up (wrapping) to lo,
    // then alternate full legs lo->hi and hi->lo; each leg end is one completed turn.
    function automatic void build_traj(int c0, int l, int h, int t);
        int c;
        exp_cnt.delete();
        exp_tc.delete();
        c = c0;
        do begin
            c = (c + 1) % 16;
            exp_cnt.push_back(c);
            exp_tc.push_back(0);
        end while (c != l);
        for (int k = 1; k <= t; k++) begin
            if (k % 2 == 1) begin
                for (int v = l + 1; v <= h; v++) begin
                    exp_cnt.push_back(v);
                    exp_tc.push_back((v == h) ? k : k - 1);
                end
            end else begin
                for (int v = h - 1; v >= l; v--) begin
                    exp_cnt.push_back(v);
                    exp_tc.push_back((v == l) ? k : k - 1);
                end
            end
        end
    endfunction

    task automatic do_start(input int l, input int h, input int t, output int c0);
        lo    = 4'(l);
        hi    = 4'(h);
        turns = 8'(t);
        start = 1'b1;
        c0    = int'(count);
        tick;
        start = 1'b0;
        lo    = 4'($urandom);
        hi    = 4'($urandom);
        turns = 8'($urandom);
    endtask

    task automatic follow_run(input string tag, input int t, input int inject_at);
        int n;
        int em;
        int last;
        n = exp_cnt.size();
        for (int i = 0; i < n; i++) begin
            last = (i == n - 1) ? 1 : 0;
            if (last == 1) em = 1;
            else em = (((exp_cnt[i+1] - exp_cnt[i] + 16) % 16) == 1) ? 1 : 0;
            chk({tag, " count"}, count, exp_cnt[i]);
            chk({tag, " m"}, m, em);
            chk({tag, " busy"}, busy, 1 - last);
            chk({tag, " done"}, done, last);
            chk({tag, " turn_cnt"}, turn_cnt, exp_tc[i]);
            if (i == inject_at) begin
                start = 1'b1;
                lo    = 4'($urandom);
                hi    = 4'($urandom);
                turns = 8'($urandom);
            end
            tick;
            start = 1'b0;
        end
        chk({tag, " post busy"}, busy, 0);
        chk({tag, " post done"}, done, 0);
        chk({tag, " post m"}, m, 1);
        chk({tag, " post count"}, count, (exp_cnt[n-1] + 1) % 16);
        chk({tag, " post turn_cnt"}, turn_cnt, t);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[12];
        int   ex_cnt[10] = '{1, 2, 3, 4, 5, 6, 5, 4, 3, 4};
        int   ex_m[10]   = '{1, 1, 1, 1, 1, 0, 0, 0, 1, 1};
        int   ex_tc[10]  = '{0, 0, 0, 0, 0, 1, 1, 1, 2, 2};
        int   c0;
        int   l, h, t, ok, k, saw_done;

        vecs[0]  = '{5, 6, 1, 0};
        vecs[1]  = '{3, 3, 2, 0};
        vecs[2]  = '{4, 6, 0, 0};
        vecs[3]  = '{4, 6, 1, 1};
        vecs[4]  = '{0, 2, 1, 1};
        vecs[5]  = '{13, 15, 3, 1};
        vecs[6]  = '{14, 15, 1, 0};
        vecs[7]  = '{15, 0, 1, 0};
        vecs[8]  = '{0, 15, 255, 1};
        vecs[9]  = '{9, 2, 1, 0};
        vecs[10] = '{0, 1, 7, 0};
        vecs[11] = '{6, 9, 0, 0};

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        lo    = '0;
        hi    = '0;
        turns = '0;
        tick;
        tick;
        chk("reset m", m, 1);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset cfg_err", cfg_err, 0);
        chk("reset turn_cnt", turn_cnt, 0);
        chk("reset count", count, 0);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            chk("idle count", count, i % 16);
            chk("idle m", m, 1);
            chk("idle busy", busy, 0);
            chk("idle turn_cnt", turn_cnt, 0);
            tick;
        end

        wait_count(0, "ex align");
        do_start(3, 6, 2, c0);
        for (int i = 0; i < 10; i++) begin
            chk("ex count", count, ex_cnt[i]);
            chk("ex m", m, ex_m[i]);
            chk("ex turn_cnt", turn_cnt, ex_tc[i]);
            chk("ex done", done, (i == 8) ? 1 : 0);
            chk("ex busy", busy, (i < 8) ? 1 : 0);
            tick;
        end

        wait_count(0, "full align");
        do_start(0, 15, 3, c0);
        build_traj(c0, 0, 15, 3);
        follow_run("full", 3, -1);

        foreach (vecs[i]) begin
            do_start(vecs[i].l, vecs[i].h, vecs[i].t, c0);
            chk("vec cfg_err", cfg_err, 1 - vecs[i].valid);
            chk("vec busy", busy, vecs[i].valid);
            chk("vec m", m, 1);
            tick;
            chk("vec cfg_err pulse", cfg_err, 0);
            abort = 1'b1;
            tick;
            abort = 1'b0;
            chk("vec idle", busy, 0);
        end

        do_start(2, 9, 4, c0);
        k = 0;
        while (m !== 1'b0 && k < 60) begin
            tick;
            k++;
        end
        chk("abort reach down", m, 0);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort m", m, 1);
        chk("abort turn_cnt", turn_cnt, 1);
        saw_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1 || busy === 1'b1) saw_done = 1;
            tick;
        end
        chk("abort stays idle", saw_done, 0);

        wait_count(0, "ign align");
        do_start(4, 7, 2, c0);
        build_traj(c0, 4, 7, 2);
        follow_run("ign", 2, 6);

        for (int r = 0; r < 25; r++) begin
            k = $urandom_range(0, 5);
            for (int j = 0; j < k; j++) tick;
            if ($urandom_range(0, 5) == 0) begin
                l = $urandom_range(0, 15);
                h = $urandom_range(0, 15);
                t = $urandom_range(0, 4);
            end else begin
                l = $urandom_range(0, 13);
                h = $urandom_range(l + 2, 15);
                t = $urandom_range(1, 4);
            end
            ok = (h >= l + 2 && t != 0) ? 1 : 0;
            do_start(l, h, t, c0);
            if (ok == 1) begin
                build_traj(c0, l, h, t);
                follow_run("rand", t, -1);
            end else begin
                chk("rand cfg_err", cfg_err, 1);
                chk("rand busy", busy, 0);
                tick;
                chk("rand cfg_err pulse", cfg_err, 0);
            end
        end

        wait_count(0, "rst align");
        do_start(1, 4, 4, c0);
        k = 0;
        while (!(turn_cnt === 8'd2 && m === 1'b1) && k < 40) begin
            tick;
            k++;
        end
        chk("rst reach up", turn_cnt, 2);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("rst count", count, 0);
        chk("rst m", m, 1);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst cfg_err", cfg_err, 0);
        chk("rst turn_cnt", turn_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_bounce_ctrl.md
# updown_bounce_ctrl

- Direction controller that sits directly upstream of the 4-bit up/down counter `Up_Down_Counter`.
- Watches the counter's `count` output and drives its mode input `m` (1 = up, 0 = down).
- After a `start`, the counter sweeps back and forth between programmable limits `lo` and `hi`, turning exactly at each limit, for a programmed number of turns. It then hands the counter back to free-running up-count.
- Shares `clk` and `reset` with the counter.

## Interface
- `WIDTH`, 4: width of `count`, `lo`, `hi`.
- `BW`, 8: width of the turn target and turn counter.
- `clk` in 1: rising-edge clock, same clock as the counter.
- `reset` in 1: synchronous, active-high; same net as the counter reset.
- `start` in 1: one-cycle request; samples `lo`, `hi`, `turns`.
- `abort` in 1: return to IDLE on the next edge.
- `lo` in WIDTH: lower turn limit.
- `hi` in WIDTH: upper turn limit.
- `turns` in BW: number of direction reversals to perform.
- `count` in WIDTH: the counter's current output.
- `m` out 1: counter mode, 1 = up, 0 = down.
- `busy` out 1: high in SEEK, UP and DOWN.
- `done` out 1: one-cycle pulse, high during the DONE state.
- `cfg_err` out 1: one-cycle pulse when a `start` is rejected.
- `turn_cnt` out BW: reversals completed in the current run.

## Operation
- States and mode output:
  - IDLE: `m`=1.
  - SEEK: `m`=1.
  - UP: `m`=1.
  - DOWN: `m`=0.
  - DONE: `m`=1.
  - `m` is a pure decode of the registered state; no combinational path from `count` to `m`.
- Reset values: state IDLE, `m`=1, `busy`=0, `done`=0, `cfg_err`=0, `turn_cnt`=0, `lo_q`/`hi_q`/`tgt_q`=0.
- IDLE:
  - On `start`, the configuration is valid iff `hi` >= `lo`+2 (evaluated in WIDTH+1 bits) and `turns` != 0.
  - Valid: capture `lo_q`, `hi_q`, `tgt_q`; clear `turn_cnt`; go to SEEK.
  - Invalid: pulse `cfg_err` next cycle and stay in IDLE.
- SEEK: the counter free-runs up and wraps mod 2^WIDTH. When `count` == `lo_q`, go to UP. Worst case is 2^WIDTH cycles.
- UP: when `count` == `hi_q`−1, turn to DOWN and increment `turn_cnt`. The counter reaches `hi_q` on that same edge.
- DOWN: when `count` == `lo_q`+1, turn to UP and increment `turn_cnt`. The counter reaches `lo_q` on that same edge.
- Turn is the last one: if the incremented `turn_cnt` == `tgt_q`, go to DONE instead of reversing.
- DONE: one cycle, `done`=1, then IDLE.
- Turn prediction is one count early because `m` is registered. The counter steps on the same edge that updates `m`, so the turning value is exactly `hi_q` or `lo_q`, with no overshoot.
- `start` is ignored while not in IDLE.
- Live `lo`/`hi`/`turns` are used only at `start`.
- `abort` has priority over all transitions except `reset`: go to IDLE next edge, `done` not asserted, `turn_cnt` holds its value.
- `reset` mid-run: every output returns to its reset value on that edge. The counter returns to 0 on the same edge.
- `turn_cnt` never wraps, because the run ends at `tgt_q` <= 2^BW−1.

## Timing
- Latency from `count` match to `m` change: 1 clock.
- Latency from `start` to `busy`: 1 clock.
- Example, with `lo`=3, `hi`=6, `turns`=2, `start` while `count`=0. Values are counter outputs, one per cycle:
  - `count`: 0,1,2,3,4,5,6,5,4,3,4.
  - `m` is 0 exactly while `count` is 6,5,4 on the way down.
  - `turn_cnt` goes to 1 as `count` becomes 6, and to 2 as `count` becomes 3.
  - `done` is high while `count`=3.
- Minimum span `hi`=`lo`+2 gives the sequence lo, lo+1, lo+2, lo+1, lo, …

## Structure
- Package `updown_pkg` holds:
  - the state enum (IDLE, SEEK, UP, DOWN, DONE);
  - default `WIDTH` and `BW` constants;
  - the `cfg_ok(lo, hi, turns)` function.
- Single module; no sub-module. Bench instantiates this block plus `Up_Down_Counter` in a closed loop.

## Test plan
- Reset, then idle for 20 cycles: `m`=1, `busy`=0, `turn_cnt`=0, counter wraps 15→0.
- `lo`=3, `hi`=6, `turns`=2, `start` at `count`=0: count sequence 0..6,5,4,3,4; `done` pulses once while `count`=3; `busy` then drops.
- `lo`=0, `hi`=15, `turns`=3, closed loop: counter never wraps; turns land on 15, 0, 15; `turn_cnt`=3 at `done`.
- Invalid starts, `lo`=5/`hi`=6, or `turns`=0: `cfg_err` pulses for one cycle, state stays IDLE, `m`=1.
- `abort` in DOWN, then a new `start` pulsed mid-run: `abort` gives IDLE next edge with no `done`; a second `start` pulsed while `busy` is ignored.
- `reset` asserted mid-run in UP: next cycle all outputs are at reset values and `count`=0.
